// File: rtl/mips_pkg.sv
// Shared encodings and pipeline register layouts for the MIPS datapath stages.
package mips_pkg;

  typedef enum logic [2:0] {
    BHW_B  = 3'b000,
    BHW_H  = 3'b001,
    BHW_W  = 3'b010,
    BHW_BU = 3'b100,
    BHW_HU = 3'b101
  } bhw_e;

  // Forwarding mux selects used by EX to pick operand sources.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX_M = 2'b01;
  localparam logic [1:0] FWD_M_WB = 2'b10;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [2:0]  bhw;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic [2:0]  bhw;
    logic [1:0]  off;
    logic        misaligned;
  } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Word-organised data RAM with per-byte write enables and a registered,
// read-first output that can be held while the pipeline is frozen.
module data_memory #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      o_rdata <= mem[i_addr];
    end
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, byte-enabled data memory access, MEM/WB register,
// load sizing/extension and writeback data selection.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  input  logic [31:0] i_ex_alu_result,
  input  logic [31:0] i_ex_write_data,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_read,
  input  logic        i_ex_mem_write,
  input  logic        i_ex_mem_to_reg,
  input  logic        i_ex_reg_write,
  input  logic [2:0]  i_ex_bhw_type,
  output logic [31:0] o_ex_m_alu_result,
  output logic [4:0]  o_ex_m_rd,
  output logic        o_ex_m_reg_write,
  output logic [31:0] o_m_wb_data_write,
  output logic [4:0]  o_m_wb_rd,
  output logic        o_m_wb_reg_write,
  output logic        o_m_wb_misaligned
);

  localparam int AW = $clog2(DMEM_WORDS);

  function automatic logic is_misaligned(logic [2:0] bhw, logic [1:0] off);
    logic r;
    case (bhw)
      BHW_B, BHW_BU: r = 1'b0;
      BHW_H, BHW_HU: r = off[0];
      default:       r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_enables(logic [2:0] bhw, logic [1:0] off);
    logic [3:0] r;
    case (bhw)
      BHW_B, BHW_BU: r = 4'b0001 << off;
      BHW_H, BHW_HU: r = off[1] ? 4'b1100 : 4'b0011;
      default:       r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(logic [2:0] bhw, logic [31:0] data);
    logic [31:0] r;
    case (bhw)
      BHW_B, BHW_BU: r = {4{data[7:0]}};
      BHW_H, BHW_HU: r = {2{data[15:0]}};
      default:       r = data;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] format_load(logic [2:0] bhw, logic [1:0] off,
                                              logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (bhw)
      BHW_B:   r = {{24{b[7]}}, b};
      BHW_BU:  r = {24'b0, b};
      BHW_H:   r = {{16{h[15]}}, h};
      BHW_HU:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  ex_mem_t ex_m;
  mem_wb_t m_wb;

  logic [1:0]    mem_off;
  logic [AW-1:0] mem_addr;
  logic          mem_misaligned;
  logic          dmem_we;
  logic [31:0]   dmem_rdata;
  logic [31:0]   load_data;

  assign mem_off        = ex_m.alu_result[1:0];
  assign mem_addr       = ex_m.alu_result[AW+1:2];
  assign mem_misaligned = (ex_m.mem_read | ex_m.mem_write) & is_misaligned(ex_m.bhw, mem_off);
  // Reset also blocks the write so a store caught in EX/MEM never lands.
  assign dmem_we        = ex_m.mem_write & ~mem_misaligned & ~i_halt & ~i_reset;

  data_memory #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_en    (~i_halt),
    .i_we    (dmem_we),
    .i_be    (byte_enables(ex_m.bhw, mem_off)),
    .i_addr  (mem_addr),
    .i_wdata (store_lanes(ex_m.bhw, ex_m.write_data)),
    .o_rdata (dmem_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_m <= '0;
      m_wb <= '0;
    end else if (!i_halt) begin
      ex_m.alu_result <= i_ex_alu_result;
      ex_m.write_data <= i_ex_write_data;
      ex_m.rd         <= i_ex_rd;
      ex_m.mem_read   <= i_ex_mem_read;
      ex_m.mem_write  <= i_ex_mem_write;
      ex_m.mem_to_reg <= i_ex_mem_to_reg;
      ex_m.reg_write  <= i_ex_reg_write;
      ex_m.bhw        <= i_ex_bhw_type;

      m_wb.alu_result <= ex_m.alu_result;
      m_wb.rd         <= ex_m.rd;
      m_wb.reg_write  <= ex_m.reg_write;
      m_wb.mem_to_reg <= ex_m.mem_to_reg;
      m_wb.bhw        <= ex_m.bhw;
      m_wb.off        <= mem_off;
      m_wb.misaligned <= mem_misaligned;
    end
  end

  assign load_data = m_wb.misaligned ? 32'b0 : format_load(m_wb.bhw, m_wb.off, dmem_rdata);

  assign o_ex_m_alu_result = ex_m.alu_result;
  assign o_ex_m_rd         = ex_m.rd;
  assign o_ex_m_reg_write  = ex_m.reg_write;
  assign o_m_wb_data_write = m_wb.mem_to_reg ? load_data : m_wb.alu_result;
  assign o_m_wb_rd         = m_wb.rd;
  assign o_m_wb_reg_write  = m_wb.reg_write;
  assign o_m_wb_misaligned = m_wb.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected writebacks queued at issue, popped two edges later.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_halt;
  logic [31:0] i_ex_alu_result;
  logic [31:0] i_ex_write_data;
  logic [4:0]  i_ex_rd;
  logic        i_ex_mem_read;
  logic        i_ex_mem_write;
  logic        i_ex_mem_to_reg;
  logic        i_ex_reg_write;
  logic [2:0]  i_ex_bhw_type;
  logic [31:0] o_ex_m_alu_result;
  logic [4:0]  o_ex_m_rd;
  logic        o_ex_m_reg_write;
  logic [31:0] o_m_wb_data_write;
  logic [4:0]  o_m_wb_rd;
  logic        o_m_wb_reg_write;
  logic        o_m_wb_misaligned;

  mem_stage #(.DMEM_WORDS(256)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_halt            (i_halt),
    .i_ex_alu_result   (i_ex_alu_result),
    .i_ex_write_data   (i_ex_write_data),
    .i_ex_rd           (i_ex_rd),
    .i_ex_mem_read     (i_ex_mem_read),
    .i_ex_mem_write    (i_ex_mem_write),
    .i_ex_mem_to_reg   (i_ex_mem_to_reg),
    .i_ex_reg_write    (i_ex_reg_write),
    .i_ex_bhw_type     (i_ex_bhw_type),
    .o_ex_m_alu_result (o_ex_m_alu_result),
    .o_ex_m_rd         (o_ex_m_rd),
    .o_ex_m_reg_write  (o_ex_m_reg_write),
    .o_m_wb_data_write (o_m_wb_data_write),
    .o_m_wb_rd         (o_m_wb_rd),
    .o_m_wb_reg_write  (o_m_wb_reg_write),
    .o_m_wb_misaligned (o_m_wb_misaligned)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mr, mw, m2r, rw;
    logic [2:0]  bhw;
    logic [31:0] exp_data;
    logic        exp_mis;
  } op_t;

  op_t sb[$];
  op_t last_wb;
  int  checks = 0;
  int  errors = 0;

  function automatic op_t mk(logic [31:0] alu, logic [31:0] wdata, logic [4:0] rd,
                             logic mr, logic mw, logic m2r, logic rw, logic [2:0] bhw,
                             logic [31:0] exp_data, logic exp_mis);
    op_t o;
    o.alu = alu; o.wdata = wdata; o.rd = rd; o.mr = mr; o.mw = mw;
    o.m2r = m2r; o.rw = rw; o.bhw = bhw; o.exp_data = exp_data; o.exp_mis = exp_mis;
    return o;
  endfunction

  // Stores write back their address (mem_to_reg=0).
  function automatic op_t st(logic [2:0] bhw, logic [31:0] addr, logic [31:0] data, logic mis);
    return mk(addr, data, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, bhw, addr, mis);
  endfunction

  function automatic op_t ld(logic [2:0] bhw, logic [31:0] addr, logic [4:0] rd,
                             logic [31:0] exp_data, logic mis);
    return mk(addr, 32'h0, rd, 1'b1, 1'b0, 1'b1, 1'b1, bhw, exp_data, mis);
  endfunction

  function automatic op_t bubble();
    return mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, W, 32'h0, 1'b0);
  endfunction

  task automatic drive(op_t o);
    i_ex_alu_result = o.alu;
    i_ex_write_data = o.wdata;
    i_ex_rd         = o.rd;
    i_ex_mem_read   = o.mr;
    i_ex_mem_write  = o.mw;
    i_ex_mem_to_reg = o.m2r;
    i_ex_reg_write  = o.rw;
    i_ex_bhw_type   = o.bhw;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_wb(string tag, op_t e);
    chk({tag, ".wb_data"}, o_m_wb_data_write, e.exp_data);
    chk({tag, ".wb_rd"}, {27'b0, o_m_wb_rd}, {27'b0, e.rd});
    chk({tag, ".wb_rw"}, {31'b0, o_m_wb_reg_write}, {31'b0, e.rw});
    chk({tag, ".wb_mis"}, {31'b0, o_m_wb_misaligned}, {31'b0, e.exp_mis});
  endtask

  task automatic issue(string tag, op_t o);
    drive(o);
    sb.push_back(o);
    @(posedge i_clk);
    #1;
    chk({tag, ".exm_alu"}, o_ex_m_alu_result, o.alu);
    chk({tag, ".exm_rd"}, {27'b0, o_ex_m_rd}, {27'b0, o.rd});
    chk({tag, ".exm_rw"}, {31'b0, o_ex_m_reg_write}, {31'b0, o.rw});
    if (sb.size() >= 2) begin
      last_wb = sb.pop_front();
      check_wb(tag, last_wb);
    end
  endtask

  // Reset is asserted together with halt and a live op on the inputs.
  task automatic do_reset(string tag);
    i_reset = 1'b1;
    i_halt  = 1'b1;
    drive(mk(32'h0000_0ABC, 32'h1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, W, 32'h0, 1'b0));
    @(posedge i_clk);
    #1;
    chk({tag, ".exm_alu"}, o_ex_m_alu_result, 32'h0);
    chk({tag, ".exm_rd"}, {27'b0, o_ex_m_rd}, 32'h0);
    chk({tag, ".exm_rw"}, {31'b0, o_ex_m_reg_write}, 32'h0);
    check_wb(tag, bubble());
    sb.delete();
    sb.push_back(bubble());
    i_reset = 1'b0;
    i_halt  = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0;
    i_halt  = 1'b0;
    drive(bubble());
    do_reset("rst0");

    issue("sw_dead", st(W, 32'h10, 32'hDEAD_BEEF, 1'b0));
    issue("lw_dead", ld(W, 32'h10, 5'd5, 32'hDEAD_BEEF, 1'b0));

    issue("sw_clr10", st(W, 32'h10, 32'h0, 1'b0));
    issue("sb_a5", st(B, 32'h11, 32'h0000_00A5, 1'b0));
    issue("lw_a500", ld(W, 32'h10, 5'd1, 32'h0000_A500, 1'b0));
    issue("lb_a5", ld(B, 32'h11, 5'd2, 32'hFFFF_FFA5, 1'b0));
    issue("lbu_a5", ld(BU, 32'h11, 5'd3, 32'h0000_00A5, 1'b0));
    issue("lb_zero", ld(B, 32'h10, 5'd4, 32'h0, 1'b0));

    issue("sw_clr20", st(W, 32'h20, 32'h0, 1'b0));
    issue("sh_8001", st(H, 32'h22, 32'h0000_8001, 1'b0));
    issue("lh_8001", ld(H, 32'h22, 5'd10, 32'hFFFF_8001, 1'b0));
    issue("lhu_8001", ld(HU, 32'h22, 5'd11, 32'h0000_8001, 1'b0));
    issue("lw_20", ld(W, 32'h20, 5'd12, 32'h8001_0000, 1'b0));
    issue("sh_mis", st(H, 32'h21, 32'h0000_1234, 1'b1));
    issue("lw_20_keep", ld(W, 32'h20, 5'd13, 32'h8001_0000, 1'b0));
    issue("lh_mis", ld(H, 32'h21, 5'd14, 32'h0, 1'b1));
    issue("lw_mis", ld(W, 32'h22, 5'd15, 32'h0, 1'b1));

    issue("alu_1234", mk(32'h1234, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, W, 32'h1234, 1'b0));

    issue("sw_wrap", st(W, 32'h430, 32'hCAFE_F00D, 1'b0));
    issue("lw_wrap", ld(W, 32'h30, 5'd16, 32'hCAFE_F00D, 1'b0));
    issue("lw_wrap2", ld(W, 32'h830, 5'd17, 32'hCAFE_F00D, 1'b0));

    issue("sw_50", st(W, 32'h50, 32'h1111_1111, 1'b0));
    issue("sb_lane3", st(B, 32'h53, 32'h0000_00EE, 1'b0));
    issue("lw_50a", ld(W, 32'h50, 5'd18, 32'hEE11_1111, 1'b0));
    issue("sh_lo", st(H, 32'h50, 32'h0000_BEEF, 1'b0));
    issue("lw_50b", ld(W, 32'h50, 5'd19, 32'hEE11_BEEF, 1'b0));
    issue("lb_52", ld(B, 32'h52, 5'd20, 32'h0000_0011, 1'b0));
    issue("lh_50", ld(H, 32'h50, 5'd21, 32'hFFFF_BEEF, 1'b0));

    issue("sw_odd", st(3'b111, 32'h74, 32'h5A5A_0F0F, 1'b0));
    issue("ld_odd", ld(3'b011, 32'h74, 5'd8, 32'h5A5A_0F0F, 1'b0));

    issue("sw_60", st(W, 32'h60, 32'h1234_5678, 1'b0));
    issue("rdwr_60", mk(32'h60, 32'hAAAA_AAAA, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, W,
                        32'h1234_5678, 1'b0));
    issue("lw_60", ld(W, 32'h60, 5'd22, 32'hAAAA_AAAA, 1'b0));

    issue("sw_clr70", st(W, 32'h70, 32'h0, 1'b0));
    issue("lw_60b", ld(W, 32'h60, 5'd4, 32'hAAAA_AAAA, 1'b0));
    issue("sw_halt", st(W, 32'h70, 32'h1122_3344, 1'b0));
    i_halt = 1'b1;
    drive(mk(32'hFFFF, 32'h77, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, W, 32'h0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      chk("halt.exm_alu", o_ex_m_alu_result, 32'h70);
      chk("halt.exm_rw", {31'b0, o_ex_m_reg_write}, 32'h0);
      check_wb("halt", last_wb);
    end
    i_halt = 1'b0;
    issue("post_halt", bubble());
    issue("lw_70", ld(W, 32'h70, 5'd6, 32'h1122_3344, 1'b0));

    issue("sw_pend", st(W, 32'h30, 32'hBADB_ADBA, 1'b0));
    do_reset("rst_mid");
    issue("lw_30_keep", ld(W, 32'h30, 5'd23, 32'hCAFE_F00D, 1'b0));
    issue("drain0", bubble());
    issue("drain1", bubble());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
